// File: rtl/bus_dma_pkg.sv
// Shared bus definitions and DMA state type.
//   BUS_WIDTH / BUS_ACC_WIDTH : data bus width and access-size code width
//   BUS_ACC_1B/2B/4B          : access-size codes
//   dma_state_t               : copy-engine state machine states
//   acc_bytes()               : byte count of an access-size code
package bus_dma_pkg;

  localparam int unsigned BUS_WIDTH     = 32;
  localparam int unsigned BUS_ACC_WIDTH = 2;

  typedef logic [BUS_ACC_WIDTH-1:0] bus_acc_t;

  localparam bus_acc_t BUS_ACC_1B = 2'd0;
  localparam bus_acc_t BUS_ACC_2B = 2'd1;
  localparam bus_acc_t BUS_ACC_4B = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } dma_state_t;

  function automatic logic [2:0] acc_bytes(input bus_acc_t acc);
    case (acc)
      BUS_ACC_4B: return 3'd4;
      BUS_ACC_2B: return 3'd2;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/bus_dma_sizer.sv
// Access sizing: picks the widest access allowed by source/destination
// alignment and the remaining byte count.
//   src_lo_i : cur_src[1:0]
//   dst_lo_i : cur_dst[1:0]
//   rem_i    : bytes remaining
//   acc_o    : access-size code
//   n_o      : bytes moved by that access (1, 2 or 4)
module bus_dma_sizer
  import bus_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic [1:0]           src_lo_i,
  input  logic [1:0]           dst_lo_i,
  input  logic [LEN_WIDTH-1:0] rem_i,
  output bus_acc_t             acc_o,
  output logic [2:0]           n_o
);

  always_comb begin
    acc_o = BUS_ACC_1B;
    n_o   = 3'd1;
    if (src_lo_i == 2'b00 && dst_lo_i == 2'b00 && rem_i >= LEN_WIDTH'(4)) begin
      acc_o = BUS_ACC_4B;
      n_o   = 3'd4;
    end else if (!src_lo_i[0] && !dst_lo_i[0] && rem_i >= LEN_WIDTH'(2)) begin
      acc_o = BUS_ACC_2B;
      n_o   = 3'd2;
    end
  end

endmodule

// File: rtl/bus_dma.sv
// Memory-to-memory copy engine acting as a single-cycle bus initiator.
// Alternates read and write accesses of the widest legal size; reports
// completion (done), a rejected access (err via fault) or a responder
// timeout (err via watchdog), with err_addr holding the failing address.
//   clk, rstn          : clock, asynchronous active-low reset
//   start, src, dst, len : launch pulse and copy parameters
//   busy, done, err, err_addr : status
//   addr, w_rb, acc, wdata, req : bus request side
//   rdata, resp, fault : bus response side
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int unsigned VA_WIDTH  = 24,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [VA_WIDTH-1:0]      src,
  input  logic [VA_WIDTH-1:0]      dst,
  input  logic [LEN_WIDTH-1:0]     len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [VA_WIDTH-1:0]      err_addr,
  output logic [VA_WIDTH-1:0]      addr,
  output logic                     w_rb,
  output logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     wdata,
  output logic                     req,
  input  logic [BUS_WIDTH-1:0]     rdata,
  input  logic                     resp,
  input  logic                     fault
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  dma_state_t            state_q, state_d;
  logic [VA_WIDTH-1:0]   cur_src_q, cur_src_d;
  logic [VA_WIDTH-1:0]   cur_dst_q, cur_dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [VA_WIDTH-1:0]   addr_q, addr_d;
  bus_acc_t              acc_q, acc_d;
  logic                  w_rb_q, w_rb_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic [VA_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  bus_acc_t              size_acc;
  logic [2:0]            size_n;
  logic [2:0]            n_q;
  logic [LEN_WIDTH-1:0]  rem_next;

  bus_dma_sizer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_sizer (
    .src_lo_i(cur_src_q[1:0]),
    .dst_lo_i(cur_dst_q[1:0]),
    .rem_i   (rem_q),
    .acc_o   (size_acc),
    .n_o     (size_n)
  );

  assign n_q      = acc_bytes(acc_q);
  assign rem_next = rem_q - LEN_WIDTH'(n_q);

  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    w_rb_d     = w_rb_q;
    data_d     = data_q;
    err_addr_d = err_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wd_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_addr_d = '0;
          if (len != '0) begin
            cur_src_d = src;
            cur_dst_d = dst;
            rem_d     = len;
            state_d   = S_RD_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        addr_d = cur_src_q;
        acc_d  = size_acc;
        w_rb_d = 1'b0;
        if (fault) begin
          err_d      = 1'b1;
          err_addr_d = cur_src_q;
          state_d    = S_IDLE;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (resp) begin
          data_d  = rdata;
          state_d = S_WR_REQ;
        end else if (wd_q == WD_LAST) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = S_IDLE;
        end
      end
      S_WR_REQ: begin
        addr_d = cur_dst_q;
        w_rb_d = 1'b1;
        if (fault) begin
          err_d      = 1'b1;
          err_addr_d = cur_dst_q;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (resp) begin
          cur_src_d = cur_src_q + VA_WIDTH'(n_q);
          cur_dst_d = cur_dst_q + VA_WIDTH'(n_q);
          rem_d     = rem_next;
          if (rem_next == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_REQ;
          end
        end else if (wd_q == WD_LAST) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      acc_q      <= BUS_ACC_1B;
      w_rb_q     <= 1'b0;
      data_q     <= '0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      w_rb_q     <= w_rb_d;
      data_q     <= data_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
    end
  end

  // Request-phase values are driven straight from the working registers so
  // req and its address appear in the first cycle after start; the _q copies
  // then hold them through the wait states.
  always_comb begin
    addr = addr_q;
    acc  = acc_q;
    w_rb = w_rb_q;
    case (state_q)
      S_RD_REQ: begin
        addr = cur_src_q;
        acc  = size_acc;
        w_rb = 1'b0;
      end
      S_WR_REQ: begin
        addr = cur_dst_q;
        w_rb = 1'b1;
      end
      default: ;
    endcase
  end

  assign req      = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign wdata    = data_q;

endmodule
